mips_path: RTL and testbench
============================

// Module: mips_path
// PURPOSE
//  Single-cycle MIPS-subset datapath: decodes an externally supplied 32-bit instruction,
//  reads a 32x32 register file, computes with an ALU, and accesses an internal data memory.
//  Covers byte/half/word loads and stores plus basic R-type ALU ops. Sits under the CPU top;
//  instruction fetch/PC sequencing lives outside. Debug ports expose writeback and memory traffic.
// PARAMETERS
//  DMEM_WORDS  256  data memory depth in 32-bit words (byte-addressed, 1 KiB)
// PORTS
//  clock        in   1   sole clock; all state updates on rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  instruction  in   32  current instruction; held stable around the rising edge
//  wb_en        out  1   register write occurs at next edge (0 when dest is r0)
//  wb_reg       out  5   destination register
//  wb_data      out  32  value to be written
//  mem_we       out  1   store occurs at next edge
//  mem_addr     out  32  effective byte address (rs + sign-extended imm16)
//  mem_wdata    out  32  merged store word written to memory
//  dbg_sel      in   5   debug register-read select
//  dbg_data     out  32  register file[dbg_sel], combinational
// BEHAVIOUR
//  - Fields: op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0] imm[15:0]. Clock = "clock".
//  - Reset (async, reset_n=0): reg[i] <= i for i=1..31, reg0 = 0. Data memory is not reset.
//    Outputs are combinational from instruction/state, so they are valid during reset.
//  - Loads (write rt): 100000 lb sign-ext byte, 100100 lbu zero-ext byte, 100001 lh sign-ext half,
//    100101 lhu zero-ext half, 100011 lw word.
//  - Stores: 101000 sb, 101001 sh, 101011 sw. Read-modify-write only the addressed lanes.
//  - R-type op 000000, writes rd: funct 100000 add, 100010 sub, 100100 and, 100101 or,
//    101010 slt (signed, result 0/1). Unknown funct: no writeback.
//  - Any other opcode is a NOP: no register or memory write; wb_en=0, mem_we=0.
//  - Arithmetic wraps mod 2^32. No overflow traps.
//  - Addressing is big-endian. Byte at addr a is in word a[9:2], bits [31-8*a[1:0] -: 8].
//  - Half-word: a[0] ignored. Word: a[1:0] ignored. Bits above [9] ignored (wrap).
//  - mem_addr reports the unaligned computed address.
//  - Single-cycle timing: decode, read and ALU are combinational. The register and memory
//    write commit on the rising edge. Load data is visible via dbg_data after that edge.
//  - Writes to r0 are discarded. r0 always reads 0.
//  - A load whose rt equals a source of the next instruction sees the committed value
//    (no hazards exist in single-cycle operation).
//  - Reset asserted mid-sequence suppresses the pending edge write and reinitialises registers.
// STRUCTURE
//  - Shared package mips_pkg: opcode/funct localparams, ALU-op enum, field-slice helpers.
//  - One natural sub-module: mips_regfile (32x32, 2 async read ports + debug port,
//    1 sync write port, async-reset init).
//  - ALU, decoder, load extender/store merger and the memory array stay inline.
// TESTING
//  1. Reset -> dbg r15=0x0000000F, r14=0x0000000E, r0=0. All outputs defined.
//  2. sw r14,0x60(r15) -> mem_we=1, mem_addr=0x6F, word 0x6C=0x0000000E.
//     Then lw r1,0x60(r15) -> r1=0x0000000E.
//  3. sub r2,r0,r1 -> r2=0xFFFFFFF2. sb r2,0x60(r15) writes byte 0x6F only.
//     lb r3 -> 0xFFFFFFF2. lbu r4 -> 0x000000F2. Other lanes of word 0x6C unchanged (0x00).
//  4. sh r2,0x5F(r15) (addr 0x6E) -> lh r5,0x5F(r15) = 0xFFFFFFF2; lhu = 0x0000FFF2.
//  5. lw r0,0x60(r15) and unknown op 111111 -> r0 stays 0, no memory change, wb_en=0.
//  6. reset_n pulsed low between two stores -> registers back to r[i]=i.
//     The store coincident with reset is not committed.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU-op enum and field/lane helpers for mips_path
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    // Decoded instruction fields; imm overlaps rd/shamt/funct by design.
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
    } fields_t;

    function automatic fields_t split_fields(input logic [31:0] ins);
        fields_t f;
        f.op    = ins[31:26];
        f.rs    = ins[25:21];
        f.rt    = ins[20:16];
        f.rd    = ins[15:11];
        f.funct = ins[5:0];
        f.imm   = ins[15:0];
        return f;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Big-endian lane pick: lane 0 is the most significant byte.
    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [15:0] get_half(input logic [31:0] word, input logic lane);
        return lane ? word[15:0] : word[31:16];
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file, two async read ports plus debug port, one sync write
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    logic [31:0] regs [32];

    // Reset loads each register with its own index; r0 is never written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'(i);
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
    assign rdata_b  = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];
    assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : regs[dbg_sel];

endmodule

// File: rtl/mips_path.sv
// rtl/mips_path.sv - single-cycle MIPS-subset datapath with internal data memory
module mips_path
    import mips_pkg::*;
#(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instruction,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    localparam int AW = $clog2(DMEM_WORDS);

    fields_t     f;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [AW-1:0] word_idx;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic [31:0] alu_result;
    alu_op_e     alu_op;
    logic        alu_ok;
    logic        mem_commit;

    logic [31:0] dmem [DMEM_WORDS];

    assign f = split_fields(instruction);

    mips_regfile u_regfile (
        .clock    (clock),
        .reset_n  (reset_n),
        .we       (wb_en),
        .waddr    (wb_reg),
        .wdata    (wb_data),
        .raddr_a  (f.rs),
        .rdata_a  (rs_val),
        .raddr_b  (f.rt),
        .rdata_b  (rt_val),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    // Effective address is reported unaligned; the word index drops lane bits and wraps.
    assign mem_addr  = rs_val + sext16(f.imm);
    assign word_idx  = mem_addr[AW+1:2];
    assign mem_rdata = dmem[word_idx];

    // R-type function decode; unknown funct leaves alu_ok low so nothing is written.
    always_comb begin
        alu_op = ALU_ADD;
        alu_ok = 1'b0;
        case (f.funct)
            FN_ADD: begin alu_op = ALU_ADD; alu_ok = 1'b1; end
            FN_SUB: begin alu_op = ALU_SUB; alu_ok = 1'b1; end
            FN_AND: begin alu_op = ALU_AND; alu_ok = 1'b1; end
            FN_OR:  begin alu_op = ALU_OR;  alu_ok = 1'b1; end
            FN_SLT: begin alu_op = ALU_SLT; alu_ok = 1'b1; end
            default: ;
        endcase
    end

    // ALU: wrapping arithmetic, signed set-less-than.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            ALU_ADD: alu_result = rs_val + rt_val;
            ALU_SUB: alu_result = rs_val - rt_val;
            ALU_AND: alu_result = rs_val & rt_val;
            ALU_OR:  alu_result = rs_val | rt_val;
            ALU_SLT: alu_result = {31'd0, $signed(rs_val) < $signed(rt_val)};
            default: alu_result = 32'd0;
        endcase
    end

    // Load extender: pick the addressed big-endian lane and sign/zero extend.
    always_comb begin
        load_data = mem_rdata;
        case (f.op)
            OP_LB:   load_data = {{24{get_byte(mem_rdata, mem_addr[1:0])[7]}},
                                  get_byte(mem_rdata, mem_addr[1:0])};
            OP_LBU:  load_data = {24'd0, get_byte(mem_rdata, mem_addr[1:0])};
            OP_LH:   load_data = sext16(get_half(mem_rdata, mem_addr[1]));
            OP_LHU:  load_data = {16'd0, get_half(mem_rdata, mem_addr[1])};
            default: load_data = mem_rdata;
        endcase
    end

    // Store merger: overwrite only the addressed lanes of the current word.
    always_comb begin
        store_word = mem_rdata;
        case (f.op)
            OP_SB: begin
                case (mem_addr[1:0])
                    2'd0:    store_word[31:24] = rt_val[7:0];
                    2'd1:    store_word[23:16] = rt_val[7:0];
                    2'd2:    store_word[15:8]  = rt_val[7:0];
                    default: store_word[7:0]   = rt_val[7:0];
                endcase
            end
            OP_SH: begin
                if (mem_addr[1]) begin
                    store_word[15:0] = rt_val[15:0];
                end else begin
                    store_word[31:16] = rt_val[15:0];
                end
            end
            OP_SW:   store_word = rt_val;
            default: ;
        endcase
    end

    assign mem_wdata = store_word;

    // Main decode: choose writeback target/source and the store strobe.
    always_comb begin
        wb_en   = 1'b0;
        wb_reg  = f.rt;
        wb_data = load_data;
        mem_we  = 1'b0;
        case (f.op)
            OP_RTYPE: begin
                wb_reg  = f.rd;
                wb_data = alu_result;
                wb_en   = alu_ok && (f.rd != 5'd0);
            end
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
                wb_en = (f.rt != 5'd0);
            end
            OP_SB, OP_SH, OP_SW: begin
                mem_we = 1'b1;
            end
            default: ;
        endcase
    end

    // A store on an edge where reset is held is dropped.
    assign mem_commit = mem_we & reset_n;

    // Data memory write port; contents are not reset.
    always_ff @(posedge clock) begin
        if (mem_commit) begin
            dmem[word_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mips_path.sv
// tb/tb_mips_path.sv - self-checking bench for mips_path with a byte-array reference model
module tb_mips_path;

    localparam logic [5:0] T_RT  = 6'b000000;
    localparam logic [5:0] T_LB  = 6'b100000;
    localparam logic [5:0] T_LH  = 6'b100001;
    localparam logic [5:0] T_LW  = 6'b100011;
    localparam logic [5:0] T_LBU = 6'b100100;
    localparam logic [5:0] T_LHU = 6'b100101;
    localparam logic [5:0] T_SB  = 6'b101000;
    localparam logic [5:0] T_SH  = 6'b101001;
    localparam logic [5:0] T_SW  = 6'b101011;
    localparam logic [31:0] NOP  = 32'hFC00_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] instruction = NOP;
    logic [4:0]  dbg_sel = 5'd0;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 1'b0;

    always #5 clock = ~clock;

    mips_path #(.DMEM_WORDS(256)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instruction (instruction),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // Reference state: registers and a 1 KiB byte array with per-byte valid flags.
    logic [31:0] m_reg [32];
    logic [7:0]  m_byte [1024];
    bit          m_bv [1024];

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        data_known;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        wdata_known;
    } exp_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
    endtask

    function automatic exp_t predict(input logic [31:0] ins);
        exp_t e;
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic [5:0] fn;
        logic [31:0] av, bv, ea;
        logic [7:0] wb [4];
        bit wk;
        int a, h, w;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
        av = m_reg[rs]; bv = m_reg[rt];
        ea = av + {{16{ins[15]}}, ins[15:0]};
        a = int'(ea[9:0]); h = a - (a % 2); w = a - (a % 4);
        e = '0;
        e.mem_addr = ea; e.wb_reg = rt; e.data_known = 1'b1; e.wdata_known = 1'b1;
        wk = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wb[k] = m_byte[w + k];
            wk = wk & m_bv[w + k];
        end
        case (op)
            T_RT: begin
                e.wb_reg = rd;
                e.wb_en  = (rd != 5'd0);
                case (fn)
                    6'b100000: e.wb_data = av + bv;
                    6'b100010: e.wb_data = av - bv;
                    6'b100100: e.wb_data = av & bv;
                    6'b100101: e.wb_data = av | bv;
                    6'b101010: e.wb_data = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
                    default:   e.wb_en = 1'b0;
                endcase
            end
            T_LB: begin
                e.wb_en = (rt != 5'd0);
                e.wb_data = {{24{m_byte[a][7]}}, m_byte[a]};
                e.data_known = m_bv[a];
            end
            T_LBU: begin
                e.wb_en = (rt != 5'd0);
                e.wb_data = {24'd0, m_byte[a]};
                e.data_known = m_bv[a];
            end
            T_LH: begin
                e.wb_en = (rt != 5'd0);
                e.wb_data = {{16{m_byte[h][7]}}, m_byte[h], m_byte[h + 1]};
                e.data_known = m_bv[h] & m_bv[h + 1];
            end
            T_LHU: begin
                e.wb_en = (rt != 5'd0);
                e.wb_data = {16'd0, m_byte[h], m_byte[h + 1]};
                e.data_known = m_bv[h] & m_bv[h + 1];
            end
            T_LW: begin
                e.wb_en = (rt != 5'd0);
                e.wb_data = {wb[0], wb[1], wb[2], wb[3]};
                e.data_known = wk;
            end
            T_SB: begin
                e.mem_we = 1'b1; wb[a - w] = bv[7:0]; e.wdata_known = wk;
            end
            T_SH: begin
                e.mem_we = 1'b1; wb[h - w] = bv[15:8]; wb[h - w + 1] = bv[7:0];
                e.wdata_known = wk;
            end
            T_SW: begin
                e.mem_we = 1'b1;
                wb[0] = bv[31:24]; wb[1] = bv[23:16]; wb[2] = bv[15:8]; wb[3] = bv[7:0];
            end
            default: ;
        endcase
        e.mem_wdata = {wb[0], wb[1], wb[2], wb[3]};
        return e;
    endfunction

    task automatic model_commit(input logic [31:0] ins);
        exp_t e;
        logic [31:0] bv;
        int a, h, w;
        e = predict(ins);
        bv = m_reg[ins[20:16]];
        a = int'(e.mem_addr[9:0]); h = a - (a % 2); w = a - (a % 4);
        if (e.wb_en) m_reg[e.wb_reg] = e.wb_data;
        case (ins[31:26])
            T_SB: begin m_byte[a] = bv[7:0]; m_bv[a] = 1'b1; end
            T_SH: begin
                m_byte[h] = bv[15:8]; m_byte[h + 1] = bv[7:0];
                m_bv[h] = 1'b1; m_bv[h + 1] = 1'b1;
            end
            T_SW: begin
                for (int k = 0; k < 4; k++) begin
                    m_byte[w + k] = bv[31 - 8 * k -: 8];
                    m_bv[w + k] = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    // Model advances on the same edge as the DUT; reset reinitialises and suppresses the edge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_commit(instruction);
    end

    // Cycle-by-cycle comparison of every meaningful output against the model.
    always @(negedge clock) begin
        exp_t e;
        if (run) begin
            e = predict(instruction);
            chk("wb_en", {31'd0, wb_en}, {31'd0, e.wb_en});
            if (e.wb_en) begin
                chk("wb_reg", {27'd0, wb_reg}, {27'd0, e.wb_reg});
                if (e.data_known) chk("wb_data", wb_data, e.wb_data);
            end
            chk("mem_we", {31'd0, mem_we}, {31'd0, e.mem_we});
            chk("mem_addr", mem_addr, e.mem_addr);
            if (e.mem_we && e.wdata_known) chk("mem_wdata", mem_wdata, e.mem_wdata);
            chk("dbg_data", dbg_data, m_reg[dbg_sel]);
        end
    end

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rt3(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
        return {T_RT, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic step(input logic [31:0] ins, input logic [4:0] sel);
        @(posedge clock);
        #1;
        instruction = ins;
        dbg_sel = sel;
        #1;
    endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #1 dbg_sel = 5'd15;
        #1 chk("rst_r15", dbg_data, 32'h0000_000F);
        dbg_sel = 5'd14;
        #1 chk("rst_r14", dbg_data, 32'h0000_000E);
        dbg_sel = 5'd0;
        #0.5 chk("rst_r0", dbg_data, 32'h0000_0000);
        run = 1'b1;
        @(posedge clock);
        #1 reset_n = 1'b1;

        step(it(T_SW, 5'd14, 5'd15, 16'h0060), 5'd0);
        chk("sw_we", {31'd0, mem_we}, 32'd1);
        chk("sw_addr", mem_addr, 32'h0000_006F);
        chk("sw_wdata", mem_wdata, 32'h0000_000E);
        step(it(T_LW, 5'd1, 5'd15, 16'h0060), 5'd1);
        chk("lw_reg", {27'd0, wb_reg}, 32'd1);
        chk("lw_data", wb_data, 32'h0000_000E);
        step(rt3(5'd2, 5'd0, 5'd1, 6'b100010), 5'd1);
        chk("r1_after_lw", dbg_data, 32'h0000_000E);
        chk("sub_data", wb_data, 32'hFFFF_FFF2);
        step(it(T_SB, 5'd2, 5'd15, 16'h0060), 5'd2);
        chk("sb_wdata", mem_wdata, 32'h0000_00F2);
        step(it(T_LB, 5'd3, 5'd15, 16'h0060), 5'd3);
        chk("lb_data", wb_data, 32'hFFFF_FFF2);
        step(it(T_LBU, 5'd4, 5'd15, 16'h0060), 5'd3);
        chk("r3_after_lb", dbg_data, 32'hFFFF_FFF2);
        chk("lbu_data", wb_data, 32'h0000_00F2);
        step(it(T_LB, 5'd16, 5'd15, 16'h005D), 5'd4);
        chk("lb_lane0", wb_data, 32'h0000_0000);
        step(it(T_SH, 5'd2, 5'd15, 16'h005F), 5'd0);
        chk("sh_addr", mem_addr, 32'h0000_006E);
        chk("sh_wdata", mem_wdata, 32'h0000_FFF2);
        step(it(T_LH, 5'd5, 5'd15, 16'h005F), 5'd0);
        chk("lh_data", wb_data, 32'hFFFF_FFF2);
        step(it(T_LHU, 5'd6, 5'd15, 16'h005F), 5'd5);
        chk("lhu_data", wb_data, 32'h0000_FFF2);
        step(it(T_LB, 5'd17, 5'd15, 16'h005F), 5'd6);
        chk("lb_lane2", wb_data, 32'hFFFF_FFFF);
        step(it(T_LW, 5'd0, 5'd15, 16'h0060), 5'd0);
        chk("lw_r0_wb", {31'd0, wb_en}, 32'd0);
        step(32'hFFFF_FFFF, 5'd0);
        chk("nop_wb", {31'd0, wb_en}, 32'd0);
        chk("nop_we", {31'd0, mem_we}, 32'd0);
        step(rt3(5'd7, 5'd14, 5'd15, 6'b100000), 5'd7);
        chk("add_data", wb_data, 32'h0000_001D);
        step(rt3(5'd8, 5'd2, 5'd15, 6'b100100), 5'd8);
        chk("and_data", wb_data, 32'h0000_0002);
        step(rt3(5'd9, 5'd14, 5'd1, 6'b100101), 5'd9);
        chk("or_data", wb_data, 32'h0000_000E);
        step(rt3(5'd10, 5'd2, 5'd15, 6'b101010), 5'd10);
        chk("slt_neg", wb_data, 32'h0000_0001);
        step(rt3(5'd11, 5'd15, 5'd2, 6'b101010), 5'd10);
        chk("slt_pos", wb_data, 32'h0000_0000);
        step(rt3(5'd12, 5'd14, 5'd15, 6'b000000), 5'd12);
        chk("badfn_wb", {31'd0, wb_en}, 32'd0);
        step(it(T_LW, 5'd12, 5'd15, 16'h0460), 5'd12);
        chk("wrap_addr", mem_addr, 32'h0000_046F);
        chk("wrap_data", wb_data, 32'h0000_FFF2);
        step(it(T_SW, 5'd2, 5'd15, 16'hFFFD), 5'd12);
        chk("neg_addr", mem_addr, 32'h0000_000C);
        step(it(T_LHU, 5'd13, 5'd15, 16'hFFFF), 5'd13);
        chk("neg_lhu", wb_data, 32'h0000_FFF2);

        step(it(T_SW, 5'd14, 5'd15, 16'h0075), 5'd0);
        chk("sw84_addr", mem_addr, 32'h0000_0084);
        step(it(T_SW, 5'd7, 5'd15, 16'h0071), 5'd0);
        chk("sw80_wdata", mem_wdata, 32'h0000_001D);
        step(it(T_SW, 5'd2, 5'd15, 16'h0075), 5'd2);
        reset_n = 1'b0;
        #1 chk("rst_mid_r2", dbg_data, 32'h0000_0002);
        step(NOP, 5'd7);
        reset_n = 1'b1;
        chk("rst_mid_r7", dbg_data, 32'h0000_0007);
        step(it(T_LW, 5'd20, 5'd15, 16'h0075), 5'd20);
        chk("rst_store_dropped", wb_data, 32'h0000_000E);
        step(it(T_LW, 5'd21, 5'd15, 16'h0071), 5'd20);
        chk("r20_after_lw", dbg_data, 32'h0000_000E);
        chk("lw80_data", wb_data, 32'h0000_001D);
        step(NOP, 5'd21);
        chk("r21_after_lw", dbg_data, 32'h0000_001D);

        @(posedge clock);
        #1 run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
